// File: rtl/register.sv
// WIDTH-bit storage register with load enable and an asynchronous active-high
// reset. Q is driven straight from the state flops.
`timescale 1ns/1ps

module register #(
    parameter int                 WIDTH       = 16,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // An unknown load_en poisons the whole word in simulation instead of
    // silently holding; synthesis is free to pick either branch.
    always_comb begin
        data_d = data_q;
        case (load_en)
            1'b1:    data_d = D;
            1'b0:    data_d = data_q;
            default: data_d = 'x;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign Q = data_q;

endmodule

// File: tb/tb_register.sv
// Scoreboard bench for register: expected Q values are queued when stimulus is
// applied and popped for comparison just after each rising edge.
`timescale 1ns/1ps

module tb_register;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             load_en;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] model_q;
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] exp_v;
    int               n_checks;
    int               n_fail;

    register #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (16'h0000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load_en (load_en),
        .D       (D),
        .Q       (Q)
    );

    // 20 ns period: 10 ns high, 10 ns low, rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Drive inputs 2 ns before the rising edge, update the reference model,
    // queue the expected value, then wait until just after the edge.
    task automatic apply(input logic r, input logic le, input logic [WIDTH-1:0] d);
        @(negedge clk);
        #8;
        reset   = r;
        load_en = le;
        D       = d;
        if (r)       model_q = 16'h0000;
        else if (le) model_q = d;
        sb.push_back(model_q);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        load_en = 1'b1;
        D       = 16'hFFFF;
        model_q = 16'h0000;
        #1;
        sb.push_back(model_q);
        got = Q; exp_v = sb.pop_front(); n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL reset_async_power_up: Q=%h expected %h", got, exp_v);
        end
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 16'hFFFF);
            got = Q; exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: Q=%h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_basic_load();
        logic [WIDTH-1:0] vals [2] = '{16'h1234, 16'hABCD};
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, vals[i]);
            got = Q; exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL basic_load %0d: Q=%h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        logic [WIDTH-1:0] vals [3] = '{16'h0000, 16'hFFFF, 16'h5555};
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, vals[i]);
            got = Q; exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v || got !== 16'hABCD) begin
                n_fail++;
                $display("FAIL hold %0d: Q=%h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_patterns();
        logic [WIDTH-1:0] vals [4] = '{16'hAAAA, 16'h5555, 16'h8001, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, vals[i]);
            got = Q; exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL pattern %0d: Q=%h expected %h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_midcycle_reset();
        // Q is FFFF here; pulse reset for 5 ns inside the low phase.
        @(negedge clk);
        load_en = 1'b0;
        #2;
        reset   = 1'b1;
        model_q = 16'h0000;
        sb.push_back(model_q);
        #1;
        got = Q; exp_v = sb.pop_front(); n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL midcycle_reset_immediate: Q=%h expected %h", got, exp_v);
        end
        #4;
        reset = 1'b0;
        sb.push_back(model_q);
        #1;
        got = Q; exp_v = sb.pop_front(); n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL midcycle_reset_before_edge: Q=%h expected %h", got, exp_v);
        end
        apply(1'b0, 1'b0, 16'h1357);
        got = Q; exp_v = sb.pop_front(); n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL midcycle_reset_after_edge: Q=%h expected %h", got, exp_v);
        end
    endtask

    task automatic test_reset_beats_load();
        apply(1'b1, 1'b1, 16'h7777);
        got = Q; exp_v = sb.pop_front(); n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL reset_beats_load: Q=%h expected %h", got, exp_v);
        end
        apply(1'b0, 1'b1, 16'h7777);
        got = Q; exp_v = sb.pop_front(); n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL release_then_load: Q=%h expected %h", got, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            apply(1'b0, 1'($urandom_range(0, 1)), WIDTH'($urandom));
            got = Q; exp_v = sb.pop_front(); n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back %0d: Q=%h expected %h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic_load();
        test_hold();
        test_patterns();
        test_midcycle_reset();
        test_reset_beats_load();
        test_back_to_back();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
